// File: rtl/cdr_dpll.sv
// Phase-differentiating CDR with a DPLL window tracker.
// It slices one bit per window, tracks early/late timing and reports lock.
module cdr_dpll #(
    parameter int PHASE_W  = 6,
    parameter int OSR      = 5,
    parameter int ACC_W    = 10,
    parameter int LOCK_CNT = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic               valid_i,
    output logic               data_o,
    output logic               valid_o,
    output logic               lock_o,
    output logic [1:0]         adj_o
);
    localparam int KW     = $clog2(OSR + 2);
    localparam int LW     = $clog2(LOCK_CNT + 1);
    localparam int SW     = ((ACC_W > PHASE_W) ? ACC_W : PHASE_W) + 1;
    localparam int AMAX_I = 2 ** (ACC_W - 1) - 1;
    localparam int HALF   = OSR / 2;

    localparam logic signed [SW-1:0] AMAX = SW'(AMAX_I);
    localparam logic signed [SW-1:0] AMIN = -SW'(AMAX_I);

    logic signed [PHASE_W-1:0] prev_q, prev_d;
    logic                      pvld_q, pvld_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [KW-1:0]             k_q, k_d;
    logic [KW-1:0]             len_q, len_d;
    logic [KW-1:0]             t_q, t_d;
    logic                      tvld_q, tvld_d;
    logic                      svld_q, svld_d;
    logic                      sneg_q, sneg_d;
    logic [LW-1:0]             lcnt_q, lcnt_d;
    logic                      data_q, data_d;
    logic                      valid_q, valid_d;
    logic [1:0]                adj_q, adj_d;

    logic                      accept;
    logic signed [PHASE_W-1:0] delta;
    logic                      nz;
    logic                      trans;
    logic                      close;
    logic signed [SW-1:0]      sum;
    logic signed [ACC_W-1:0]   acc_sat;
    logic                      t_hit;
    logic [KW-1:0]             t_idx;

    always_comb begin
        accept  = enable_i & valid_i;
        delta   = $signed(phase_i) - prev_q;
        nz      = delta != '0;
        trans   = nz & svld_q & (delta[PHASE_W-1] != sneg_q);
        close   = k_q == len_q - 1'b1;
        sum     = SW'(acc_q) + SW'(delta);
        acc_sat = ACC_W'(sum);
        if (sum > AMAX) acc_sat = ACC_W'(AMAX);
        if (sum < AMIN) acc_sat = ACC_W'(AMIN);
        // Earliest transition of the window, including the closing sample.
        t_hit   = tvld_q | trans;
        t_idx   = tvld_q ? t_q : k_q;
    end

    always_comb begin
        prev_d  = prev_q;
        pvld_d  = pvld_q;
        acc_d   = acc_q;
        k_d     = k_q;
        len_d   = len_q;
        t_d     = t_q;
        tvld_d  = tvld_q;
        svld_d  = svld_q;
        sneg_d  = sneg_q;
        lcnt_d  = lcnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        adj_d   = adj_q;
        if (accept) begin
            prev_d = $signed(phase_i);
            pvld_d = 1'b1;
            if (pvld_q) begin
                if (nz) begin
                    svld_d = 1'b1;
                    sneg_d = delta[PHASE_W-1];
                end
                if (trans && !tvld_q) begin
                    tvld_d = 1'b1;
                    t_d    = k_q;
                end
                if (close) begin
                    valid_d = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    tvld_d  = 1'b0;
                    if (acc_sat > 0)      data_d = 1'b1;
                    else if (acc_sat < 0) data_d = 1'b0;
                    if (!t_hit || t_idx == '0) begin
                        len_d = KW'(OSR);
                        adj_d = 2'b00;
                        if (lcnt_q != LW'(LOCK_CNT)) lcnt_d = lcnt_q + 1'b1;
                    end else if (t_idx <= KW'(HALF)) begin
                        len_d  = KW'(OSR - 1);
                        adj_d  = 2'b01;
                        lcnt_d = '0;
                    end else begin
                        len_d  = KW'(OSR + 1);
                        adj_d  = 2'b10;
                        lcnt_d = '0;
                    end
                end else begin
                    acc_d = acc_sat;
                    k_d   = k_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q  <= '0;
            pvld_q  <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
            len_q   <= KW'(OSR);
            t_q     <= '0;
            tvld_q  <= 1'b0;
            svld_q  <= 1'b0;
            sneg_q  <= 1'b0;
            lcnt_q  <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            adj_q   <= 2'b00;
        end else begin
            prev_q  <= prev_d;
            pvld_q  <= pvld_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            len_q   <= len_d;
            t_q     <= t_d;
            tvld_q  <= tvld_d;
            svld_q  <= svld_d;
            sneg_q  <= sneg_d;
            lcnt_q  <= lcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            adj_q   <= adj_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign adj_o   = adj_q;
    assign lock_o  = lcnt_q == LW'(LOCK_CNT);
endmodule

// File: tb/tb_cdr_dpll.sv
// Directed bench for cdr_dpll: slicing, wrap, tracking, lock, reset, enable.
// A second instance with ACC_W=4 exercises accumulator saturation.
module tb_cdr_dpll;
    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       enable_i = 1'b1;
    logic [5:0] phase_i = '0;
    logic       valid_i = 1'b0;
    logic       data_o, valid_o, lock_o;
    logic [1:0] adj_o;
    logic       data2, valid2, lock2;
    logic [1:0] adj2;

    int npass = 0;
    int ntot = 0;
    int pulses = 0;
    int dq[$];
    logic signed [5:0] cur;

    always #5 clk = ~clk;
    always @(posedge clk) if (valid_o) pulses++;

    cdr_dpll dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .phase_i(phase_i), .valid_i(valid_i), .data_o(data_o),
        .valid_o(valid_o), .lock_o(lock_o), .adj_o(adj_o)
    );

    cdr_dpll #(.ACC_W(4)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .phase_i(phase_i), .valid_i(valid_i), .data_o(data2),
        .valid_o(valid2), .lock_o(lock2), .adj_o(adj2)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic send(input logic signed [5:0] p, output logic vo);
        @(negedge clk);
        phase_i = p;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        vo = valid_o;
        repeat (3) @(negedge clk);
    endtask

    task automatic seed(input logic signed [5:0] p);
        logic vo;
        cur = p;
        send(cur, vo);
    endtask

    // Applies the deltas queued in dq; reports the last sample's valid_o
    // and how many pulses appeared on earlier samples.
    task automatic run_win(output logic last_vo, output int early);
        logic vo;
        early = 0;
        last_vo = 1'b0;
        for (int i = 0; i < dq.size(); i++) begin
            cur = cur + 6'(dq[i]);
            send(cur, vo);
            if (i == dq.size() - 1) last_vo = vo;
            else if (vo) early++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        ntot++; if (data_o !== 1'b0) $display("FAIL rst_data got %b want 0", data_o); else npass++;
        ntot++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_o); else npass++;
        ntot++; if (lock_o !== 1'b0) $display("FAIL rst_lock got %b want 0", lock_o); else npass++;
        ntot++; if (adj_o !== 2'b00) $display("FAIL rst_adj got %b want 00", adj_o); else npass++;
    endtask

    task automatic test_basic();
        logic vo;
        int early, p0;
        do_reset();
        seed(0);
        p0 = pulses;
        dq = '{4, 4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1) $display("FAIL basic_valid got %b want 1", vo); else npass++;
        ntot++; if (early !== 0) $display("FAIL basic_early got %0d want 0", early); else npass++;
        ntot++; if (pulses - p0 !== 1) $display("FAIL basic_pulses got %0d want 1", pulses - p0); else npass++;
        ntot++; if (data_o !== 1'b1) $display("FAIL basic_data got %b want 1", data_o); else npass++;
        ntot++; if (adj_o !== 2'b00) $display("FAIL basic_adj got %b want 00", adj_o); else npass++;
    endtask

    task automatic test_wrap();
        logic vo;
        int early;
        do_reset();
        seed(28);
        dq = '{4, 4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || data_o !== 1'b1) $display("FAIL wrap_up got v%b d%b want v1 d1", vo, data_o); else npass++;
        dq = '{-4, -4, -4, -4, -4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || data_o !== 1'b0) $display("FAIL wrap_dn got v%b d%b want v1 d0", vo, data_o); else npass++;
        ntot++; if (adj_o !== 2'b00) $display("FAIL wrap_adj got %b want 00", adj_o); else npass++;
    endtask

    task automatic test_alternating();
        logic vo, b, lk;
        int early;
        do_reset();
        seed(0);
        for (int s = 0; s < 10; s++) begin
            b = (s % 2 == 0);
            if (b) dq = '{4, 4, 4, 4, 4};
            else dq = '{-4, -4, -4, -4, -4};
            run_win(vo, early);
            lk = (s >= 7);
            ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL alt_valid s%0d got v%b e%0d want v1 e0", s, vo, early); else npass++;
            ntot++; if (data_o !== b) $display("FAIL alt_data s%0d got %b want %b", s, data_o, b); else npass++;
            ntot++; if (adj_o !== 2'b00) $display("FAIL alt_adj s%0d got %b want 00", s, adj_o); else npass++;
            ntot++; if (lock_o !== lk) $display("FAIL alt_lock s%0d got %b want %b", s, lock_o, lk); else npass++;
        end
    endtask

    task automatic test_slip();
        logic vo;
        int early;
        dq = '{-4, 4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (adj_o !== 2'b01) $display("FAIL slip1_adj got %b want 01", adj_o); else npass++;
        ntot++; if (lock_o !== 1'b0) $display("FAIL slip1_lock got %b want 0", lock_o); else npass++;
        ntot++; if (data_o !== 1'b1) $display("FAIL slip1_data got %b want 1", data_o); else npass++;
        dq = '{4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL short_len got v%b e%0d want v1 e0", vo, early); else npass++;
        ntot++; if (adj_o !== 2'b00) $display("FAIL short_adj got %b want 00", adj_o); else npass++;
        dq = '{4, 4, 4, 4, -4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL slip4_len got v%b e%0d want v1 e0", vo, early); else npass++;
        ntot++; if (adj_o !== 2'b10) $display("FAIL slip4_adj got %b want 10", adj_o); else npass++;
        dq = '{-4, -4, -4, -4, -4, -4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL long_len got v%b e%0d want v1 e0", vo, early); else npass++;
        ntot++; if (data_o !== 1'b0 || adj_o !== 2'b00) $display("FAIL long_out got d%b a%b want d0 a00", data_o, adj_o); else npass++;
    endtask

    task automatic test_zero();
        logic vo;
        int early;
        dq = '{4, 4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (data_o !== 1'b1) $display("FAIL zero_pre got %b want 1", data_o); else npass++;
        dq = '{4, -4, 4, -4, 0};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1) $display("FAIL zero_valid got %b want 1", vo); else npass++;
        ntot++; if (data_o !== 1'b1) $display("FAIL zero_hold got %b want 1", data_o); else npass++;
        ntot++; if (adj_o !== 2'b01) $display("FAIL zero_adj got %b want 01", adj_o); else npass++;
    endtask

    task automatic test_reset_mid();
        logic vo;
        int early, p0;
        p0 = pulses;
        dq = '{4, 4, 4};
        run_win(vo, early);
        do_reset();
        repeat (3) @(negedge clk);
        ntot++; if (pulses !== p0) $display("FAIL rmid_pulse got %0d want %0d", pulses, p0); else npass++;
        ntot++; if ({data_o, valid_o, lock_o, adj_o} !== 5'b0) $display("FAIL rmid_outs got %b want 00000", {data_o, valid_o, lock_o, adj_o}); else npass++;
        seed(0);
        dq = '{4, 4, 4, 4, 4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL rmid_win got v%b e%0d want v1 e0", vo, early); else npass++;
        ntot++; if (data_o !== 1'b1 || adj_o !== 2'b00) $display("FAIL rmid_out got d%b a%b want d1 a00", data_o, adj_o); else npass++;
    endtask

    task automatic test_enable();
        logic vo;
        int early, p0;
        do_reset();
        seed(0);
        dq = '{4, 4};
        run_win(vo, early);
        p0 = pulses;
        @(negedge clk);
        enable_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_i = i[0];
            phase_i = 6'(i * 11 + 30);
            @(negedge clk);
        end
        valid_i = 1'b0;
        enable_i = 1'b1;
        @(negedge clk);
        ntot++; if (pulses !== p0) $display("FAIL en_pulse got %0d want %0d", pulses, p0); else npass++;
        dq = '{4, 4, 4};
        run_win(vo, early);
        ntot++; if (vo !== 1'b1 || early !== 0) $display("FAIL en_resume got v%b e%0d want v1 e0", vo, early); else npass++;
        ntot++; if (data_o !== 1'b1 || adj_o !== 2'b00) $display("FAIL en_out got d%b a%b want d1 a00", data_o, adj_o); else npass++;
    endtask

    task automatic test_saturation();
        logic vo;
        int early;
        do_reset();
        seed(0);
        dq = '{7, 7, 7, 7, 7};
        run_win(vo, early);
        ntot++; if (valid2 !== 1'b0 || data2 !== 1'b1) $display("FAIL sat_up got d%b want 1", data2); else npass++;
        // Clamped acc runs 7,7,7,0,-7; unclamped runs 7,14,21,14,7.
        dq = '{7, 7, 7, -7, -7};
        run_win(vo, early);
        ntot++; if (data2 !== 1'b0) $display("FAIL sat_clamp got %b want 0", data2); else npass++;
        ntot++; if (data_o !== 1'b1) $display("FAIL sat_wide got %b want 1", data_o); else npass++;
        ntot++; if (adj2 !== 2'b10) $display("FAIL sat_adj got %b want 10", adj2); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_alternating();
        test_slip();
        test_zero();
        test_reset_mid();
        test_enable();
        test_saturation();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
